// File: rtl/uart_tx_pkg.sv
// Shared constants and types for the UART transmitter: FSM encoding, payload width,
// prescale floor and parity type codes.
package uart_tx_pkg;

  localparam int DATA_WIDTH = 8;

  localparam logic [4:0] PRESCALE_MIN = 5'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Prescales below the floor would make bits too short for the receiver to sample.
  function automatic logic [4:0] clamp_prescale(input logic [4:0] p);
    return (p < PRESCALE_MIN) ? PRESCALE_MIN : p;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Datapath of the transmitter: latched word and prescale, bit-cycle counter and
// bit-index counter, plus the strobes the FSM steps on.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  active,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [4:0]            prescale_in,
  output logic [DATA_WIDTH-1:0] data_q,
  output logic [IDX_W-1:0]      bit_idx,
  output logic                  bit_done,
  output logic                  last_bit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [4:0] prescale_q;
  logic [4:0] cycle_cnt;

  assign bit_done = (cycle_cnt == prescale_q - 5'd1);
  assign last_bit = (bit_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      prescale_q <= PRESCALE_MIN;
    end else if (load) begin
      data_q     <= data_in;
      prescale_q <= prescale_in;
    end
  end

  // The cycle counter wraps on every bit boundary so each bit lasts exactly prescale_q cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (load) begin
      cycle_cnt <= '0;
    end else if (active) begin
      cycle_cnt <= bit_done ? 5'd0 : cycle_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (load) begin
      bit_idx <= '0;
    end else if (advance) begin
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit, each held for
// a latched prescale count of oversampling-clock cycles. Outputs are registered.
module uart_tx #(
  parameter int DATA_WIDTH = uart_tx_pkg::DATA_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_data_valid,
  input  logic                   i_par_en,
  input  logic                   i_par_typ,
  input  logic [4:0]             i_prescale,
  output logic                   o_tx,
  output logic                   o_busy,
  output uart_tx_pkg::tx_state_e o_state
);

  import uart_tx_pkg::*;

  localparam int IDX_W = $clog2(DATA_WIDTH);

  // Handshake: a word is taken on any rising edge where i_data_valid is high and the
  // FSM is idle; o_busy is the inverse of ready, and requests while busy are dropped.
  tx_state_e state, state_next;

  logic                  tx_next, busy_next;
  logic                  accept, advance, active;
  logic                  par_en_q, par_typ_q, parity_bit;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      bit_idx, idx_next;
  logic                  bit_done, last_bit;

  assign accept   = (state == ST_IDLE) && i_data_valid;
  assign active   = (state != ST_IDLE);
  assign advance  = (state == ST_DATA) && bit_done && !last_bit;
  assign idx_next = bit_idx + IDX_W'(1);
  assign o_state  = state;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_tx_serializer (
    .clk         (i_clk),
    .rst_n       (i_rst),
    .load        (accept),
    .active      (active),
    .advance     (advance),
    .data_in     (i_data),
    .prescale_in (clamp_prescale(i_prescale)),
    .data_q      (data_q),
    .bit_idx     (bit_idx),
    .bit_done    (bit_done),
    .last_bit    (last_bit)
  );

  always_comb begin
    parity_bit = ^data_q;
    case (par_typ_q)
      PAR_EVEN: parity_bit = ^data_q;
      PAR_ODD:  parity_bit = ~^data_q;
      default:  parity_bit = ^data_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (accept) begin
      par_en_q  <= i_par_en;
      par_typ_q <= i_par_typ;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= ST_IDLE;
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
    end else begin
      state  <= state_next;
      o_tx   <= tx_next;
      o_busy <= busy_next;
    end
  end

  // The line level is decided one cycle early so o_tx changes on the same edge as state.
  always_comb begin
    state_next = state;
    tx_next    = o_tx;
    busy_next  = o_busy;
    case (state)
      ST_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (i_data_valid) begin
          state_next = ST_START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
          tx_next    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (!last_bit) begin
            tx_next = data_q[idx_next];
          end else if (par_en_q) begin
            state_next = ST_PARITY;
            tx_next    = parity_bit;
          end else begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_next = ST_IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
